// File: rtl/hiscore_uploader.sv
// hiscore_uploader: streams hiscore RAM to HPS on dump upload with CPU pause, dirty tracking and autosave request
module hiscore_uploader #(
  parameter int DUMPWIDTH = 10,
  parameter int DUMPINDEX = 4,
  parameter int PAUSEPAD  = 2,
  parameter int RDLAT     = 1
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ioctl_upload,
  input  logic [7:0]           ioctl_index,
  input  logic [24:0]          ioctl_addr,
  input  logic                 ioctl_rd,
  output logic [7:0]           ioctl_din,
  output logic                 ioctl_wait,
  output logic                 ioctl_upload_req,
  input  logic                 autosave,
  input  logic                 osd_status,
  input  logic                 dirty_set,
  input  logic                 paused,
  output logic                 pause_req,
  output logic [DUMPWIDTH-1:0] ram_addr,
  output logic                 ram_rd,
  input  logic [7:0]           ram_q,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, HALT, PAD, READY, FETCH} state_t;
  state_t state_q, state_d;
  logic [3:0] pad_q, pad_d;
  logic [1:0] lat_q, lat_d;
  logic [7:0] din_q, din_d;
  logic [DUMPWIDTH-1:0] addr_q, addr_d;
  logic upload_q, osd_q, dirty_q, dirty_d, wait_q, wait_d, pause_q, pause_d;
  logic req_q, req_d, ram_rd_q, ram_rd_d;
  logic up_rise, up_fall, osd_rise, in_range;
  assign up_rise = ioctl_upload & ~upload_q;
  assign up_fall = ~ioctl_upload & upload_q;
  assign osd_rise = osd_status & ~osd_q;
  assign in_range = ioctl_addr[24:DUMPWIDTH] == '0;
  assign ioctl_din = din_q;
  assign ioctl_wait = wait_q;
  assign ioctl_upload_req = req_q;
  assign pause_req = pause_q;
  assign busy = pause_q;
  assign ram_addr = addr_q;
  assign ram_rd = ram_rd_q;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pad_q    <= '0;
      lat_q    <= '0;
      din_q    <= '0;
      addr_q   <= '0;
      upload_q <= 1'b0;
      osd_q    <= 1'b0;
      dirty_q  <= 1'b0;
      wait_q   <= 1'b0;
      pause_q  <= 1'b0;
      req_q    <= 1'b0;
      ram_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pad_q    <= pad_d;
      lat_q    <= lat_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      upload_q <= ioctl_upload;
      osd_q    <= osd_status;
      dirty_q  <= dirty_d;
      wait_q   <= wait_d;
      pause_q  <= pause_d;
      req_q    <= req_d;
      ram_rd_q <= ram_rd_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    pad_d    = pad_q;
    lat_d    = lat_q;
    din_d    = din_q;
    addr_d   = addr_q;
    wait_d   = wait_q;
    pause_d  = pause_q;
    dirty_d  = dirty_q;
    req_d    = 1'b0;
    ram_rd_d = 1'b0;
    if (state_q != IDLE && up_fall) begin
      state_d = IDLE;
      pause_d = 1'b0;
      wait_d  = 1'b0;
      dirty_d = (state_q == READY || state_q == FETCH) ? 1'b0 : dirty_q;
    end else begin
      case (state_q)
        IDLE:
          if (up_rise && ioctl_index == 8'(DUMPINDEX)) begin
            state_d = HALT;
            pause_d = 1'b1;
            wait_d  = 1'b1;
          end else req_d = osd_rise & autosave & dirty_q;
        HALT:
          if (paused) begin
            state_d = (PAUSEPAD == 0) ? READY : PAD;
            pad_d   = 4'(PAUSEPAD);
            wait_d  = PAUSEPAD != 0;
          end
        PAD: begin
          pad_d = pad_q - 4'd1;
          if (pad_q <= 4'd1) begin
            state_d = READY;
            wait_d  = 1'b0;
          end
        end
        // wait_q is only high here on the cycle after an out-of-range read
        READY:
          if (wait_q) wait_d = 1'b0;
          else if (ioctl_rd) begin
            wait_d = 1'b1;
            if (in_range) begin
              addr_d   = ioctl_addr[DUMPWIDTH-1:0];
              ram_rd_d = 1'b1;
              lat_d    = '0;
              state_d  = FETCH;
            end else din_d = 8'h00;
          end
        FETCH:
          if (lat_q == 2'(RDLAT)) begin
            din_d   = ram_q;
            wait_d  = 1'b0;
            state_d = READY;
          end else lat_d = lat_q + 2'd1;
        default: state_d = IDLE;
      endcase
    end
    if (dirty_set) dirty_d = 1'b1;
  end
endmodule

// File: doc/hiscore_uploader.md
# hiscore_uploader

Serves the upload (core-to-HPS) direction of the ioctl NVRAM channel: when the HPS reads back dump index 4, this block pauses the CPU, streams hiscore RAM bytes onto `ioctl_din` under `ioctl_wait` flow control, then releases the pause. It also tracks whether hiscore RAM has been written since the last dump. When autosave is enabled, it requests an upload on OSD open. It sits between `hps_io` and the hiscore dual-port RAM, alongside the download path that writes that RAM.

## Interface
Parameters:
- `DUMPWIDTH`, 10, hiscore RAM address width; dump size is 2^DUMPWIDTH bytes.
- `DUMPINDEX`, 4, `ioctl_index` value that selects this block.
- `PAUSEPAD`, 2, settle cycles after `paused` before the first read is accepted (range 0–15).
- `RDLAT`, 1, RAM read latency in clocks (range 1–3).

Ports:
- `clk_sys` in 1: system clock (40 MHz).
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_upload` in 1: HPS upload in progress.
- `ioctl_index` in 8: selected file index.
- `ioctl_addr` in 25: byte address requested by HPS.
- `ioctl_rd` in 1: single-cycle read strobe from HPS.
- `ioctl_din` out 8: read data to HPS.
- `ioctl_wait` out 1: HPS must not issue `ioctl_rd` while high.
- `ioctl_upload_req` out 1: single-cycle request to HPS to start an upload.
- `autosave` in 1: autosave enable (OSD option).
- `osd_status` in 1: OSD open.
- `dirty_set` in 1: CPU wrote the hiscore area this cycle.
- `paused` in 1: CPU is halted (from the pause block).
- `pause_req` out 1: request CPU halt.
- `ram_addr` out DUMPWIDTH: hiscore RAM read address.
- `ram_rd` out 1: RAM read enable, single cycle.
- `ram_q` in 8: RAM read data, valid RDLAT cycles after `ram_rd`.
- `busy` out 1: dump session active.

## Operation
- Every output resets to 0 asynchronously.
- The `dirty` flag also resets to 0.
- FSM states:
  - IDLE: on the rising edge of `ioctl_upload` with `ioctl_index==DUMPINDEX`, set `pause_req`, `busy` and `ioctl_wait` to 1, then go to HALT. Uploads with any other index are ignored; `ioctl_din` and `ioctl_wait` stay 0.
  - HALT: wait for `paused`=1, then load the pad counter with PAUSEPAD and go to PAD.
  - PAD: decrement the counter each cycle. At 0, clear `ioctl_wait` and go to READY. With PAUSEPAD=0, go straight to READY.
  - READY:
    - On `ioctl_rd`, set `ioctl_wait`.
    - If `ioctl_addr[24:DUMPWIDTH]==0`, drive `ram_addr=ioctl_addr[DUMPWIDTH-1:0]`, pulse `ram_rd` and go to FETCH.
    - Otherwise (out of range), load `ioctl_din=8'h00` and stay in READY; `ioctl_wait` drops the next cycle.
  - FETCH: count RDLAT cycles, then register `ram_q` into `ioctl_din`, clear `ioctl_wait` and return to READY.
- Falling `ioctl_upload` in any non-IDLE state aborts the session:
  - `pause_req`, `busy` and `ioctl_wait` go to 0 and the FSM returns to IDLE.
  - `dirty` clears, but only if the FSM had reached READY or FETCH.
  - `ioctl_din` holds its value.
- `ioctl_rd` outside READY is ignored. This includes a strobe while `ioctl_wait` is high.
- `dirty` is set by `dirty_set` and cleared on session end.
  - If `dirty_set` and session end fall on the same cycle, `dirty` ends up 1.
- Autosave: in IDLE, on the rising edge of `osd_status` with `autosave=1` and `dirty=1`, pulse `ioctl_upload_req` for exactly one cycle. No pulse is issued outside IDLE.
- `ram_rd` never asserts outside FETCH entry, so the RAM is read-only from this block.

## Timing
- Upload edge sampled at cycle N: `pause_req`, `busy` and `ioctl_wait` are high from N+1.
- `paused` first seen high at cycle P: `ioctl_wait` low at P+1+PAUSEPAD.
- In-range `ioctl_rd` at cycle T:
  - `ram_rd` and `ram_addr` valid at T+1.
  - `ioctl_wait` high over T+1 … T+1+RDLAT.
  - `ioctl_din` valid and `ioctl_wait` low at T+2+RDLAT.
  - Back-to-back read throughput is one byte per RDLAT+2 cycles.
- Out-of-range read at T: `ioctl_din=0` and `ioctl_wait` low at T+2.
- `ioctl_upload_req`: OSD edge seen at cycle O, pulse at O+1, one cycle wide.
- All inputs from `hps_io` are already in `clk_sys`; edge detectors use one register stage.

## Test plan
- Reset: assert `reset_n=0` mid-FETCH → all outputs 0 within the same cycle; after release, FSM is IDLE and `dirty=0`.
- Full dump, PAUSEPAD=2, RDLAT=1, RAM[k]=k^8'h5A:
  - Start upload at index 4; `paused` goes high 5 cycles after `pause_req`; read addresses 0..1023 honoring `ioctl_wait`.
  - Required: every byte matches, `ioctl_wait` drops 3 cycles after each `ioctl_rd`, `pause_req` is 0 one cycle after `ioctl_upload` falls.
- Wrong index: upload at index 0 with `ioctl_rd` strobes → `pause_req`, `ram_rd` and `ioctl_wait` stay 0.
- Out-of-range: read `ioctl_addr=0x400` → `ioctl_din=0x00`, no `ram_rd`, `ioctl_wait` low 2 cycles later.
- Autosave:
  - `dirty_set` pulse, `autosave=1`, then an `osd_status` rising edge → one-cycle `ioctl_upload_req`.
  - Repeat with `dirty=0` → no pulse.
  - Repeat with `autosave=0` → no pulse.
- Race and abort:
  - `dirty_set` on the same cycle `ioctl_upload` falls after a complete dump → `dirty` remains 1.
  - Abort the upload during HALT → `pause_req` drops and `dirty` is unchanged.
